// File: rtl/cavlc_pkg.sv
// cavlc_pkg: shared types, constants and coeff_token code tables for the
// pipelined CAVLC coeff_token decoder.
//   nc_class_t  : table class chosen from nC
//   CT_LEN/CODE : code length / right-aligned codeword, index TC*4+T1, for
//                 classes T0 (nC 0..1), T1 (nC 2..3), T2 (nC 4..7); len 0 = unused
//   CDC_LEN/CODE: same layout for chroma DC (nC = -1), TC 0..4
//   ct_match    : does a table entry match a window given as (LZC, suffix)?
package cavlc_pkg;

    typedef enum logic [2:0] {NC_T0, NC_T1, NC_T2, NC_FLC, NC_CDC} nc_class_t;

    localparam int         MAX_CT_LEN = 16;
    localparam int         FLC_LEN    = 6;
    localparam logic [5:0] FLC_ZERO   = 6'b000011;

    localparam int CT_N  = 68;
    localparam int CDC_N = 20;

    typedef logic [MAX_CT_LEN-1:0] ct_win_t;

    localparam int CT_LEN [3][CT_N] = '{
        '{ 1, 0, 0, 0,   6, 2, 0, 0,   8, 6, 3, 0,   9, 8, 7, 5,  10, 9, 8, 6,
          11,10, 9, 7,  13,11,10, 8,  13,13,11, 9,  13,13,13,10,
          14,14,13,11,  14,14,14,13,  15,15,14,14,  15,15,15,14,
          16,15,15,15,  16,16,16,15,  16,16,16,16,  16,16,16,16},
        '{ 2, 0, 0, 0,   6, 2, 0, 0,   6, 5, 3, 0,   7, 6, 6, 4,   8, 6, 6, 4,
           8, 7, 7, 5,   9, 8, 8, 6,  11, 9, 9, 6,  11,11,11, 7,
          12,11,11, 9,  12,12,12,11,  12,12,12,11,  13,13,13,12,
          13,13,13,13,  13,14,13,13,  14,14,14,13,  14,14,14,14},
        '{ 4, 0, 0, 0,   6, 4, 0, 0,   6, 5, 4, 0,   6, 5, 5, 4,   7, 5, 5, 4,
           7, 5, 5, 4,   7, 6, 6, 4,   7, 6, 6, 4,   8, 7, 7, 5,
           8, 8, 7, 6,   9, 8, 8, 7,   9, 9, 8, 8,   9, 9, 9, 8,
          10, 9, 9, 9,  10,10,10,10,  10,10,10,10,  10,10,10,10}
    };

    localparam int CT_CODE [3][CT_N] = '{
        '{ 1, 0, 0, 0,   5, 1, 0, 0,   7, 4, 1, 0,   7, 6, 5, 3,   7, 6, 5, 3,
           7, 6, 5, 4,  15, 6, 5, 4,  11,14, 5, 4,   8,10,13, 4,
          15,14, 9, 4,  11,10,13,12,  15,14, 9,12,  11,10,13, 8,
          15, 1, 9,12,  11,14,13, 8,   7,10, 9,12,   4, 6, 5, 8},
        '{ 3, 0, 0, 0,  11, 2, 0, 0,   7, 7, 3, 0,   7,10, 9, 5,   7, 6, 5, 4,
           4, 6, 5, 6,   7, 6, 5, 8,  15, 6, 5, 4,  11,14,13, 4,
          15,10, 9, 4,  11,14,13,12,   8,10, 9, 8,  15,14,13,12,
          11,10, 9,12,   7,11, 6, 8,   9, 8,10, 1,   7, 6, 5, 4},
        '{15, 0, 0, 0,  15,14, 0, 0,  11,15,13, 0,   8,12,14,12,  15,10,11,11,
          11, 8, 9,10,   9,14,13, 9,   8,10, 9, 8,  15,14,13,13,
          11,14,10,12,  15,10,13,12,  11,14, 9,12,   8,10,13, 8,
          13, 7, 9,12,   9,12,11,10,   5, 8, 7, 6,   1, 4, 3, 2}
    };

    localparam int CDC_LEN  [CDC_N] = '{2,0,0,0, 6,1,0,0, 6,6,3,0, 6,7,7,6, 6,8,8,7};
    localparam int CDC_CODE [CDC_N] = '{1,0,0,0, 7,1,0,0, 4,6,1,0, 3,3,2,5, 2,3,2,0};

    // Every codeword is zeros^lz, '1', rest -- so it matches when the window
    // LZC equals lz and the suffix starts with rest. The all-zero codeword
    // (chroma DC TC=4,T1=3) matches any window with at least len leading zeros.
    function automatic logic ct_match(input int lzc, input ct_win_t suf,
                                      input int len, input int code);
        ct_win_t al, rest, mask;
        int      lz;
        logic    found;
        ct_match = 1'b0;
        if (len > 0) begin
            al    = ct_win_t'(code) << (MAX_CT_LEN - len);
            lz    = len;
            found = 1'b0;
            for (int i = 0; i < MAX_CT_LEN; i++) begin
                if (!found && al[MAX_CT_LEN-1-i]) begin
                    lz    = i;
                    found = 1'b1;
                end
            end
            if (lz >= len) begin
                ct_match = (lzc >= len);
            end else if (lzc == lz) begin
                rest     = al << (lz + 1);
                mask     = ~({MAX_CT_LEN{1'b1}} >> (len - lz - 1));
                ct_match = ((suf ^ rest) & mask) == '0;
            end
        end
    endfunction

endpackage

// File: rtl/coeff_token_lzc.sv
// coeff_token_lzc: combinational leading-zero counter.
//   din_i [WIN_W] : window, MSB first
//   cnt_o [CW]    : number of leading zeros, WIN_W when din_i is all zero
module coeff_token_lzc #(
    parameter int WIN_W = 16,
    parameter int CW    = $clog2(WIN_W + 1)
) (
    input  logic [WIN_W-1:0] din_i,
    output logic [CW-1:0]    cnt_o
);

    // Scan upward from the LSB; the last set bit seen is the most significant.
    always_comb begin
        cnt_o = CW'(WIN_W);
        for (int i = 0; i < WIN_W; i++) begin
            if (din_i[i]) cnt_o = CW'(WIN_W - 1 - i);
        end
    end

endmodule

// File: rtl/coeff_token_decoder.sv
// coeff_token_decoder: two-stage pipelined CAVLC coeff_token decoder.
//   Clk, Rst_n           : clock, synchronous active-low reset
//   InValid/InReady      : input handshake for Bits (MSB = next bit) and NC
//   OutValid/OutReady    : output handshake
//   TotalCoeff, TrailingOnes, CodeLen, Error : decoded token (zeros + Error=1
//                          when nothing legal matched)
//   ErrCount             : saturating count of Error results handed over
// Stage 1 registers LZC, table class and the bits after the first '1';
// stage 2 registers the table lookup. WIN_W must be at least 16.
module coeff_token_decoder
    import cavlc_pkg::*;
#(
    parameter int WIN_W     = 16,
    parameter int NC_W      = 6,
    parameter int CHROMA_DC = 1,
    parameter int ERRCNT_W  = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                InValid,
    output logic                InReady,
    input  logic [WIN_W-1:0]    Bits,
    input  logic [NC_W-1:0]     NC,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [4:0]          TotalCoeff,
    output logic [1:0]          TrailingOnes,
    output logic [4:0]          CodeLen,
    output logic                Error,
    output logic [ERRCNT_W-1:0] ErrCount
);

    localparam int LZW = $clog2(WIN_W + 1);

    // ---------------- handshake ----------------
    logic s1v_q, s2v_q;
    logic s1_ld, s2_ld;

    assign s2_ld   = !s2v_q || OutReady;
    assign s1_ld   = !s1v_q || s2_ld;
    assign InReady = s1_ld;

    // ---------------- stage 1 ----------------
    logic [LZW-1:0]   lzc_d, lzc_q;
    nc_class_t        cls_d, cls_q;
    logic [WIN_W-1:0] sh;
    ct_win_t          suf_d, suf_q;
    logic signed [NC_W-1:0] nc_s;

    coeff_token_lzc #(.WIN_W(WIN_W), .CW(LZW)) u_lzc (
        .din_i (Bits),
        .cnt_o (lzc_d)
    );

    // Drop the leading zeros and the terminating '1'; a zero window shifts out entirely.
    assign sh    = Bits << (int'(lzc_d) + 1);
    assign suf_d = sh[WIN_W-1 -: MAX_CT_LEN];
    assign nc_s  = $signed(NC);

    always_comb begin
        cls_d = NC_FLC;
        if      (nc_s < 0) cls_d = NC_CDC;
        else if (nc_s < 2) cls_d = NC_T0;
        else if (nc_s < 4) cls_d = NC_T1;
        else if (nc_s < 8) cls_d = NC_T2;
    end

    // ---------------- stage 2 lookup ----------------
    logic       hit;
    logic [4:0] tc_d, tc_q, len_d, len_q;
    logic [1:0] t1_d, t1_q;
    logic       err_d, err_q;
    logic [5:0] flc_b;
    int         lzc_i, tbl;

    assign lzc_i = int'(lzc_q);

    always_comb begin
        hit   = 1'b0;
        tc_d  = 5'd0;
        t1_d  = 2'd0;
        len_d = 5'd0;
        flc_b = 6'd0;
        tbl   = 0;
        case (cls_q)
            NC_T0, NC_T1, NC_T2: begin
                tbl = int'(cls_q);
                for (int i = 0; i < CT_N; i++) begin
                    if (ct_match(lzc_i, suf_q, CT_LEN[tbl][i], CT_CODE[tbl][i])) begin
                        hit   = 1'b1;
                        tc_d  = 5'(i / 4);
                        t1_d  = 2'(i % 4);
                        len_d = 5'(CT_LEN[tbl][i]);
                    end
                end
            end
            NC_CDC: begin
                if (CHROMA_DC != 0) begin
                    for (int i = 0; i < CDC_N; i++) begin
                        if (ct_match(lzc_i, suf_q, CDC_LEN[i], CDC_CODE[i])) begin
                            hit   = 1'b1;
                            tc_d  = 5'(i / 4);
                            t1_d  = 2'(i % 4);
                            len_d = 5'(CDC_LEN[i]);
                        end
                    end
                end
            end
            NC_FLC: begin
                // Rebuild the raw 6-bit field: lz zeros, a '1', then suffix bits.
                flc_b = (6'b100000 >> lzc_q) | ({1'b0, suf_q[MAX_CT_LEN-1 -: 5]} >> lzc_q);
                hit   = 1'b1;
                len_d = 5'(FLC_LEN);
                if (flc_b != FLC_ZERO) begin
                    tc_d = {1'b0, flc_b[5:2]} + 5'd1;
                    t1_d = flc_b[1:0];
                    if ({3'b000, t1_d} > tc_d) hit = 1'b0;
                end
            end
            default: ;
        endcase
        if (lzc_i == WIN_W) hit = 1'b0;
        err_d = !hit;
        if (!hit) begin
            tc_d  = 5'd0;
            t1_d  = 2'd0;
            len_d = 5'd0;
        end
    end

    // ---------------- error counter ----------------
    logic [ERRCNT_W-1:0] errcnt_d, errcnt_q;

    always_comb begin
        errcnt_d = errcnt_q;
        if (s2v_q && OutReady && err_q && (errcnt_q != {ERRCNT_W{1'b1}}))
            errcnt_d = errcnt_q + ERRCNT_W'(1);
    end

    // ---------------- registers ----------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            s1v_q    <= 1'b0;
            lzc_q    <= '0;
            cls_q    <= NC_T0;
            suf_q    <= '0;
            s2v_q    <= 1'b0;
            tc_q     <= 5'd0;
            t1_q     <= 2'd0;
            len_q    <= 5'd0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
            if (s1_ld) begin
                s1v_q <= InValid;
                if (InValid) begin
                    lzc_q <= lzc_d;
                    cls_q <= cls_d;
                    suf_q <= suf_d;
                end
            end
            if (s2_ld) begin
                s2v_q <= s1v_q;
                if (s1v_q) begin
                    tc_q  <= tc_d;
                    t1_q  <= t1_d;
                    len_q <= len_d;
                    err_q <= err_d;
                end
            end
        end
    end

    assign OutValid     = s2v_q;
    assign TotalCoeff   = tc_q;
    assign TrailingOnes = t1_q;
    assign CodeLen      = len_q;
    assign Error        = err_q;
    assign ErrCount     = errcnt_q;

endmodule

// File: tb/tb_coeff_token_decoder.sv
// tb_coeff_token_decoder: directed-vector bench. A scoreboard queue holds the
// hand-computed result for each accepted token; a negedge monitor checks every
// delivered result. A second instance has the chroma DC table disabled.
module tb_coeff_token_decoder;

    localparam int WIN_W = 16;
    localparam int NC_W  = 6;
    localparam int ECW   = 8;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             InValid = 1'b0;
    logic             OutReady = 1'b1;
    logic [WIN_W-1:0] Bits = '0;
    logic [NC_W-1:0]  NC = '0;

    logic InReady, OutValid, Error;
    logic [4:0] TotalCoeff, CodeLen;
    logic [1:0] TrailingOnes;
    logic [ECW-1:0] ErrCount;

    logic InReady_z, OutValid_z, Error_z;
    logic [4:0] TotalCoeff_z, CodeLen_z;
    logic [1:0] TrailingOnes_z;
    logic [ECW-1:0] ErrCount_z;

    coeff_token_decoder #(.WIN_W(WIN_W), .NC_W(NC_W), .CHROMA_DC(1), .ERRCNT_W(ECW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
        .Bits(Bits), .NC(NC), .OutValid(OutValid), .OutReady(OutReady),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .CodeLen(CodeLen),
        .Error(Error), .ErrCount(ErrCount));

    coeff_token_decoder #(.WIN_W(WIN_W), .NC_W(NC_W), .CHROMA_DC(0), .ERRCNT_W(ECW)) dut_z (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady_z),
        .Bits(Bits), .NC(NC), .OutValid(OutValid_z), .OutReady(OutReady),
        .TotalCoeff(TotalCoeff_z), .TrailingOnes(TrailingOnes_z), .CodeLen(CodeLen_z),
        .Error(Error_z), .ErrCount(ErrCount_z));

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [4:0] tc;
        logic [1:0] t1;
        logic [4:0] len;
        logic       err;
    } exp_t;

    exp_t exq[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   out_n = 0;
    exp_t mon_e;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Rst_n && OutValid && OutReady) begin
            if (exq.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                mon_e = exq.pop_front();
                chk($sformatf("tc#%0d", out_n), TotalCoeff, mon_e.tc);
                chk($sformatf("t1#%0d", out_n), TrailingOnes, mon_e.t1);
                chk($sformatf("len#%0d", out_n), CodeLen, mon_e.len);
                chk($sformatf("err#%0d", out_n), Error, mon_e.err);
                pop_cyc.push_back(cyc);
            end
            out_n++;
        end
    end

    // Drive a token, wait (bounded) for its accepting edge, then queue its result.
    task automatic send(input int nc, input logic [15:0] bits,
                        input int tc, input int t1, input int len, input int err);
        logic rdy;
        exp_t e;
        NC      = NC_W'(nc);
        Bits    = bits;
        InValid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            rdy = InReady;
            @(posedge Clk);
            if (rdy) begin
                e.tc  = 5'(tc);
                e.t1  = 2'(t1);
                e.len = 5'(len);
                e.err = 1'(err);
                exq.push_back(e);
                #1;
                InValid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        InValid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exq.size() != 0; k++) @(posedge Clk);
        if (exq.size() != 0) begin
            chk("drain_timeout", exq.size(), 0);
            exq.delete();
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_outvalid", OutValid, 0);
        chk("rst_errcount", ErrCount, 0);
        chk("rst_tc", TotalCoeff, 0);
        chk("rst_len", CodeLen, 0);
        chk("rst_error", Error, 0);
        Rst_n = 1'b1;
        #1;
        chk("rst_inready", InReady, 1);
        chk("rst_inready_z", InReady_z, 1);

        // 1: single token, two-edge latency
        send(0, 16'h8000, 0, 0, 1, 0);
        chk("lat_edge1", OutValid, 0);
        @(posedge Clk);
        #1;
        chk("lat_edge2", OutValid, 1);
        drain();

        // 2: back-to-back, no bubble
        send(1, 16'h1400, 1, 0, 6, 0);
        send(3, 16'hBFFF, 1, 1, 2, 0);
        drain();
        n = pop_cyc.size();
        chk("no_bubble", (n >= 2) ? pop_cyc[n-1] - pop_cyc[n-2] : 0, 1);

        // 3: other classes and long codes
        send(5, 16'hF000, 0, 0, 4, 0);
        send(7, 16'hF000, 0, 0, 4, 0);
        send(9, 16'h0C00, 0, 0, 6, 0);
        send(9, 16'hFC00, 16, 3, 6, 0);
        send(8, 16'h5800, 6, 2, 6, 0);
        send(2, 16'hC000, 0, 0, 2, 0);
        send(2, 16'h001C, 16, 0, 14, 0);
        send(4, 16'h0040, 16, 0, 10, 0);
        send(0, 16'h0008, 16, 3, 16, 0);
        send(0, 16'h0002, 13, 1, 15, 0);
        drain();

        // 4: chroma DC, and the instance without it
        chk("z_errcnt0", ErrCount_z, 0);
        send(-1, 16'h8000, 1, 1, 1, 0);
        @(posedge Clk);
        #1;
        chk("z_outvalid", OutValid_z, 1);
        chk("z_error", Error_z, 1);
        chk("z_len", CodeLen_z, 0);
        chk("z_tc", TotalCoeff_z, 0);
        chk("z_t1", TrailingOnes_z, 0);
        @(posedge Clk);
        #1;
        chk("z_errcnt1", ErrCount_z, 1);
        send(-1, 16'h4000, 0, 0, 2, 0);
        send(-32, 16'h0100, 4, 3, 7, 0);
        send(-1, 16'h0300, 4, 1, 8, 0);
        send(9, 16'h0800, 0, 0, 0, 1);
        send(0, 16'h0001, 0, 0, 0, 1);
        drain();
        chk("errcnt2", ErrCount, 2);

        // 5: stall with OutReady low
        OutReady = 1'b0;
        fork
            begin
                send(0, 16'h8000, 0, 0, 1, 0);
                send(1, 16'h1400, 1, 0, 6, 0);
                send(3, 16'hBFFF, 1, 1, 2, 0);
                send(9, 16'hFC00, 16, 3, 6, 0);
            end
            begin
                @(posedge Clk);
                @(posedge Clk);
                #2;
                chk("stall_inready", InReady, 0);
                chk("stall_valid", OutValid, 1);
                chk("stall_len0", CodeLen, 1);
                @(posedge Clk);
                #2;
                chk("stall_len1", CodeLen, 1);
                @(posedge Clk);
                #2;
                chk("stall_len2", CodeLen, 1);
                chk("stall_tc2", TotalCoeff, 0);
                OutReady = 1'b1;
            end
        join
        drain();

        // 6: zero windows, saturation, reset with full pipe
        for (int i = 0; i < 300; i++) send(0, 16'h0000, 0, 0, 0, 1);
        drain();
        chk("errcnt_sat", ErrCount, 255);
        chk("errcnt_sat_z", ErrCount_z, 255);

        OutReady = 1'b0;
        send(0, 16'h8000, 0, 0, 1, 0);
        send(0, 16'h8000, 0, 0, 1, 0);
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        exq.delete();
        chk("rst2_outvalid", OutValid, 0);
        chk("rst2_errcount", ErrCount, 0);
        chk("rst2_errcount_z", ErrCount_z, 0);
        chk("rst2_inready", InReady, 1);
        Rst_n = 1'b1;
        OutReady = 1'b1;
        send(5, 16'hF000, 0, 0, 4, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
